// File: rtl/rv32i_pkg.sv
// Shared RV32I core definitions: datapath widths, ALU funct3 encodings and the
// ID/EX pipeline register layout.
package rv32i_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [XLEN-1:0]       rs1_data;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rd_addr;
    alu_op_t               op;
    logic                  sub_sra;
    logic                  use_imm;
    logic                  reg_write;
  } id_ex_t;

  // Immediate forms only carry a real funct7 bit for shifts; ADDI etc. reuse bit 30 as imm.
  function automatic logic sub_sra_of(input logic is_rtype, input alu_op_t op,
                                      input logic inst30);
    logic r;
    if (is_rtype) begin
      r = inst30;
    end else if (op == ALU_SR) begin
      r = inst30;
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute handshake bundle: decoded instruction in, ALU operand set out.
interface id_ex_stage_if;
  import rv32i_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       in_pc;
  logic [REG_ADDR_W-1:0] in_rs1_addr;
  logic [REG_ADDR_W-1:0] in_rs2_addr;
  logic [XLEN-1:0]       in_rs1_data;
  logic [XLEN-1:0]       in_rs2_data;
  logic [XLEN-1:0]       in_imm;
  logic [REG_ADDR_W-1:0] in_rd_addr;
  logic [2:0]            in_funct3;
  logic                  in_inst30;
  logic                  in_is_rtype;
  logic                  in_use_imm;
  logic                  in_reg_write;

  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       alu_a;
  logic [XLEN-1:0]       alu_b;
  logic [2:0]            alu_op;
  logic                  alu_sub_sra;
  logic [XLEN-1:0]       store_data;
  logic [XLEN-1:0]       out_pc;
  logic [REG_ADDR_W-1:0] out_rd_addr;
  logic                  out_reg_write;

  modport master (
    output in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_rd_addr, in_funct3, in_inst30, in_is_rtype, in_use_imm,
           in_reg_write, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_op, alu_sub_sra, store_data,
           out_pc, out_rd_addr, out_reg_write
  );

  modport slave (
    input  in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_rd_addr, in_funct3, in_inst30, in_is_rtype, in_use_imm,
           in_reg_write, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_op, alu_sub_sra, store_data,
           out_pc, out_rd_addr, out_reg_write
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Three-source operand select: EX/MEM result, then WB result, then the stored value.
module fwd_mux
  import rv32i_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]       stored_data,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [XLEN-1:0]       mem_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic [XLEN-1:0]       data
);

  logic addr_nz_s;

  assign addr_nz_s = (addr != {REG_ADDR_W{1'b0}});

  // Younger producer wins; x0 is never forwarded.
  always_comb begin
    data = stored_data;
    if (mem_valid && (mem_rd == addr) && addr_nz_s) begin
      data = mem_data;
    end else if (wb_valid && (wb_rd == addr) && addr_nz_s) begin
      data = wb_data;
    end else begin
      data = stored_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: valid/ready capture with stall, flush, in-stall WB
// refresh of held operands, and output-side operand forwarding into the ALU.
module id_ex_stage
  import rv32i_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  fwd_mem_valid,
  input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0]       fwd_mem_data,
  input  logic                  fwd_wb_valid,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]       fwd_wb_data,
  id_ex_stage_if.slave          bus
);

  localparam logic [REG_ADDR_W-1:0] X0 = {REG_ADDR_W{1'b0}};

  logic     valid_q, valid_d;
  id_ex_t   ex_q, ex_d;
  id_ex_t   captured_s;
  logic     in_ready_s;
  logic     load_s;
  logic [XLEN-1:0] rs1_fwd_s, rs2_fwd_s;

  assign in_ready_s = !valid_q || bus.out_ready;
  assign load_s     = bus.in_valid && in_ready_s && !flush;

  // Decoded fields as they will be stored; x0 reads are forced to zero.
  always_comb begin
    captured_s.pc        = bus.in_pc;
    captured_s.rs1_addr  = bus.in_rs1_addr;
    captured_s.rs1_data  = (bus.in_rs1_addr == X0) ? {XLEN{1'b0}} : bus.in_rs1_data;
    captured_s.rs2_addr  = bus.in_rs2_addr;
    captured_s.rs2_data  = (bus.in_rs2_addr == X0) ? {XLEN{1'b0}} : bus.in_rs2_data;
    captured_s.imm       = bus.in_imm;
    captured_s.rd_addr   = bus.in_rd_addr;
    captured_s.op        = alu_op_t'(bus.in_funct3);
    captured_s.sub_sra   = sub_sra_of(bus.in_is_rtype, alu_op_t'(bus.in_funct3), bus.in_inst30);
    captured_s.use_imm   = bus.in_use_imm;
    captured_s.reg_write = bus.in_reg_write;
  end

  // Next-state: flush beats load; a stalled entry picks up WB results for its sources.
  always_comb begin
    valid_d = valid_q;
    ex_d    = ex_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_s) begin
      valid_d = 1'b1;
      ex_d    = captured_s;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      if (fwd_wb_valid && (fwd_wb_rd == ex_q.rs1_addr) && (ex_q.rs1_addr != X0)) begin
        ex_d.rs1_data = fwd_wb_data;
      end else begin
        ex_d.rs1_data = ex_q.rs1_data;
      end
      if (fwd_wb_valid && (fwd_wb_rd == ex_q.rs2_addr) && (ex_q.rs2_addr != X0)) begin
        ex_d.rs2_data = fwd_wb_data;
      end else begin
        ex_d.rs2_data = ex_q.rs2_data;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Pipeline register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ex_q    <= id_ex_t'({$bits(id_ex_t){1'b0}});
    end else begin
      valid_q <= valid_d;
      ex_q    <= ex_d;
    end
  end

  fwd_mux u_fwd_rs1 (
    .addr        (ex_q.rs1_addr),
    .stored_data (ex_q.rs1_data),
    .mem_valid   (fwd_mem_valid),
    .mem_rd      (fwd_mem_rd),
    .mem_data    (fwd_mem_data),
    .wb_valid    (fwd_wb_valid),
    .wb_rd       (fwd_wb_rd),
    .wb_data     (fwd_wb_data),
    .data        (rs1_fwd_s)
  );

  fwd_mux u_fwd_rs2 (
    .addr        (ex_q.rs2_addr),
    .stored_data (ex_q.rs2_data),
    .mem_valid   (fwd_mem_valid),
    .mem_rd      (fwd_mem_rd),
    .mem_data    (fwd_mem_data),
    .wb_valid    (fwd_wb_valid),
    .wb_rd       (fwd_wb_rd),
    .wb_data     (fwd_wb_data),
    .data        (rs2_fwd_s)
  );

  assign bus.in_ready      = in_ready_s;
  assign bus.out_valid     = valid_q;
  assign bus.alu_a         = rs1_fwd_s;
  assign bus.alu_b         = ex_q.use_imm ? ex_q.imm : rs2_fwd_s;
  assign bus.alu_op        = ex_q.op;
  assign bus.alu_sub_sra   = ex_q.sub_sra;
  assign bus.store_data    = rs2_fwd_s;
  assign bus.out_pc        = ex_q.pc;
  assign bus.out_rd_addr   = ex_q.rd_addr;
  assign bus.out_reg_write = ex_q.reg_write && valid_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and the execute-stage ALU in the RV32I core.
- Captures decoded operands and control with a valid/ready handshake, and supports stall and flush.
- Applies operand forwarding, both while holding and at its output.
- Produces the ALU operand/control set `a`, `b`, `op`, `subtract_or_arithmetic_shift`, plus the pass-through fields needed by later stages.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode presents a valid instruction
in_ready  out  1  stage can accept; = !out_valid || out_ready
in_pc  in  XLEN  instruction PC
in_rs1_addr, in_rs2_addr  in  REG_ADDR_W  source indices
in_rs1_data, in_rs2_data  in  XLEN  register-file read values
in_imm  in  XLEN  sign-extended immediate
in_rd_addr  in  REG_ADDR_W  destination index
in_funct3  in  3  instruction funct3
in_inst30  in  1  instruction bit 30
in_is_rtype  in  1  opcode is OP (R-type)
in_use_imm  in  1  ALU b selects immediate
in_reg_write  in  1  instruction writes rd
flush  in  1  kill held and incoming instruction
fwd_mem_valid  in  1  EX/MEM result valid and writes a register
fwd_mem_rd  in  REG_ADDR_W  EX/MEM destination
fwd_mem_data  in  XLEN  EX/MEM result
fwd_wb_valid  in  1  WB writing register file this cycle
fwd_wb_rd  in  REG_ADDR_W  WB destination
fwd_wb_data  in  XLEN  WB data
out_valid  out  1  ALU inputs valid
out_ready  in  1  downstream accepts
alu_a  out  XLEN  operand a (forwarded rs1)
alu_b  out  XLEN  operand b (imm or forwarded rs2)
alu_op  out  3  funct3 to ALU
alu_sub_sra  out  1  drives ALU subtract_or_arithmetic_shift
store_data  out  XLEN  forwarded rs2 value
out_pc  out  XLEN  registered PC
out_rd_addr  out  REG_ADDR_W  registered rd
out_reg_write  out  1  registered reg_write, gated by out_valid

Behaviour:
- Reset:
  - out_valid=0 and all registered fields=0.
  - Hence alu_a=0, alu_b=0, alu_op=0, alu_sub_sra=0, out_reg_write=0.
- Load:
  - When in_valid && in_ready && !flush, all fields are captured next edge and out_valid=1.
  - Latency is one cycle, with full throughput: back-to-back accepts are allowed when out_ready=1.
- Drain: when out_valid && out_ready and no new load, out_valid clears.
- Hold:
  - When out_valid && !out_ready, all fields are held, except that stored rs1/rs2 data is updated from fwd_wb when fwd_wb_valid && fwd_wb_rd==stored addr && addr!=0.
  - This update prevents stale operands after the producer retires during a stall.
- Flush:
  - Next edge out_valid=0.
  - An incoming instruction in the same cycle is discarded.
  - Flush dominates load.
- Output forwarding (combinational on registered data), with priority:
  1. EX/MEM match.
  2. WB match.
  3. Stored data.
- Forwarding match rules:
  - A match requires the valid bit, rd==addr and addr!=0.
  - x0 is never forwarded.
  - For alu_a and store_data, the stored data is x0-safe (decode supplies 0).
- alu_b = in_use_imm (registered) ? imm : forwarded rs2.
- alu_sub_sra is registered, computed at capture:
  - R-type: = inst30.
  - I-type: = inst30 only when funct3==3'b101 (SRAI/SRLI).
  - All other I-type funct3: forced 0. ADDI with a negative immediate has inst30=1 and must not subtract.
- out_reg_write = registered reg_write && out_valid.
- Reset asserted mid-stall clears out_valid regardless of out_ready.

Decomposition:
- Shared package rv32i_pkg:
  - XLEN and REG_ADDR_W constants.
  - alu_op_t enum of funct3 encodings: ADD=000, SLL=001, SLT=010, SLTU=011, XOR=100, SR=101, OR=110, AND=111.
  - id_ex_t packed struct of the registered fields.
- One natural sub-module: fwd_mux.
  - Combinational 3-source priority select.
  - Instantiated for rs1 and rs2.

Test Plan:
- Reset, then single ADD x3,x1,x2 with rs1=5, rs2=7, out_ready=1 -> one cycle later out_valid=1, alu_a=5, alu_b=7, alu_op=000, alu_sub_sra=0; next cycle out_valid=0.
- ADDI with imm=-1 (inst30=1) -> alu_b=32'hFFFFFFFF, alu_sub_sra=0. SRAI imm=3 with inst30=1 -> alu_op=101, alu_sub_sra=1. R-type SUB -> alu_sub_sra=1.
- Captured rs1=x4 (stale 0), with fwd_mem_valid, rd=4, data=32'h10 and fwd_wb rd=4, data=32'h20 asserted simultaneously -> alu_a=32'h10. Repeat with rd=0 on both -> alu_a=0.
- Hold out_ready=0 for 3 cycles with stored rs2=x6; pulse fwd_wb rd=6, data=99 in cycle 2, then release -> store_data=99 when accepted; in_ready=0 throughout the hold.
- Back-to-back 4 instructions with out_ready=1 -> 4 consecutive out_valid cycles, in order. Assert flush together with in_valid -> out_valid=0 next cycle, out_reg_write=0.
- Assert reset while out_valid=1 and out_ready=0 -> next edge out_valid=0 and all outputs 0.
